// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Brief    : Program-memory instruction sequencer. Words are loaded while
//             idle, then issued one at a time with a valid/advance handshake,
//             stopping on an end marker, the last memory word, or a watchdog
//             timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] END_WORD = '1,
    parameter int                TIMEOUT  = 16,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              clear,
    input  logic              advance,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] index,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  cycle_count
);

    // Watchdog must be able to hold TIMEOUT-1 plus one step of headroom.
    localparam int c_WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   w_rd;
    logic [ADDR_W-1:0]   r_index;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_WD_W-1:0]   r_wdog;
    logic                w_start;
    logic                w_step;

    // State register; reset drops straight to IDLE even mid-program.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; clear outranks start and advance.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_step  = 1'b0;
        w_rd    = r_mem[r_index];
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        w_next  = S_FETCH;
                        w_start = 1'b1;
                    end
                end
                S_FETCH: begin
                    w_next = (w_rd == END_WORD) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
                    // An advance on the expiring cycle still counts as progress.
                    if (advance) begin
                        if (r_index == ADDR_W'(DEPTH - 1)) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_FETCH;
                            w_step = 1'b1;
                        end
                    end else if (r_wdog == c_WD_W'(TIMEOUT - 1)) begin
                        w_next = S_ERROR;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Datapath: fetched word, word index, busy-cycle counter and watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= '0;
            r_index <= '0;
            r_cnt   <= '0;
            r_wdog  <= '0;
        end else begin
            if (r_state == S_FETCH) begin
                r_instr <= w_rd;
            end

            if (w_start) begin
                r_index <= '0;
            end else if (w_step) begin
                r_index <= r_index + 1'b1;
            end

            if (w_start) begin
                r_cnt <= '0;
            end else if ((r_state == S_FETCH || r_state == S_ISSUE) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Counts consecutive stalled ISSUE cycles; zero whenever not stalling.
            if (r_state == S_ISSUE && !advance) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign instr       = r_instr;
    assign index       = r_index;
    assign cycle_count = r_cnt;
    assign instr_valid = (r_state == S_ISSUE);
    assign done        = (r_state == S_DONE);
    assign timeout_err = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Brief    : Scoreboard bench for instr_sequencer (DEPTH=4). Stimulus pushes
//             expected issued words; a monitor pops on each new issue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int c_DW = 32;
    localparam int c_AW = 2;
    localparam int c_CW = 16;

    logic            clk;
    logic            reset;
    logic            load_en;
    logic [c_AW-1:0] load_addr;
    logic [c_DW-1:0] load_data;
    logic            start;
    logic            clear;
    logic            advance;
    logic [c_DW-1:0] instr;
    logic            instr_valid;
    logic [c_AW-1:0] index;
    logic            done;
    logic            timeout_err;
    logic [c_CW-1:0] cycle_count;

    typedef struct packed {
        logic [c_DW-1:0] word;
        logic [c_AW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic r_prev_valid = 1'b0;

    instr_sequencer #(
        .DATA_W  (c_DW),
        .DEPTH   (4),
        .ADDR_W  (c_AW),
        .END_WORD(32'hFFFF_FFFF),
        .TIMEOUT (16),
        .CNT_W   (c_CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .clear      (clear),
        .advance    (advance),
        .instr      (instr),
        .instr_valid(instr_valid),
        .index      (index),
        .done       (done),
        .timeout_err(timeout_err),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: one scoreboard pop per fresh ISSUE (valid rising at negedge).
    always @(negedge clk) begin
        if (reset && instr_valid && !r_prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {32'd0, instr}, 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_word", {32'd0, instr}, {32'd0, e.word});
                chk("issue_index", {62'd0, index}, {62'd0, e.idx});
            end
        end
        r_prev_valid = reset && instr_valid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [c_DW-1:0] w, input logic [c_AW-1:0] i);
        exp_t e;
        e.word = w;
        e.idx  = i;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 50) begin tick(); n++; end
        if (!instr_valid) chk({name, "_wait_valid"}, 64'd0, 64'd1);
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!done && !timeout_err && n < 50) begin tick(); n++; end
        if (!done && !timeout_err) chk({name, "_wait_end"}, 64'd0, 64'd1);
    endtask

    // Handshake: advance on the first cycle each word is valid.
    task automatic run_words(input int k, input string name);
        for (int i = 0; i < k; i++) begin
            wait_valid(name);
            advance = 1'b1; tick(); advance = 1'b0;
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; clear = 1'b0; advance = 1'b0;
        tick(); tick();
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_tmo", {63'd0, timeout_err}, 64'd0);
        chk("rst_index", {62'd0, index}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_cnt", {48'd0, cycle_count}, 64'd0);
        reset = 1'b1;
        tick();

        // Short program ending on the end marker.
        load(2'd0, 32'hE3A0_0005);
        load(2'd1, 32'hE280_1001);
        load(2'd2, 32'hFFFF_FFFF);
        push(32'hE3A0_0005, 2'd0);
        push(32'hE280_1001, 2'd1);
        pulse_start();
        run_words(2, "prog");
        wait_end("prog");
        chk("prog_done", {63'd0, done}, 64'd1);
        chk("prog_index", {62'd0, index}, 64'd2);
        chk("prog_cnt", {48'd0, cycle_count}, 64'd5);
        chk("prog_instr_hold", {32'd0, instr}, 64'hFFFF_FFFF);

        // Watchdog: never advance.
        pulse_clear();
        load(2'd0, 32'hE3A0_0005);
        push(32'hE3A0_0005, 2'd0);
        pulse_start();
        wait_valid("wd");
        n = 0;
        while (instr_valid && n < 40) begin tick(); n++; end
        chk("wd_valid_cycles", 64'(n), 64'd16);
        chk("wd_tmo", {63'd0, timeout_err}, 64'd1);
        chk("wd_valid_low", {63'd0, instr_valid}, 64'd0);
        chk("wd_index", {62'd0, index}, 64'd0);

        // Full memory, no marker: stops at last word without wrapping.
        pulse_clear();
        load(2'd0, 32'hA000_0000);
        load(2'd1, 32'hA000_0001);
        load(2'd2, 32'hA000_0002);
        load(2'd3, 32'hA000_0003);
        for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i), 2'(i));
        pulse_start();
        run_words(4, "full");
        wait_end("full");
        chk("full_done", {63'd0, done}, 64'd1);
        chk("full_index", {62'd0, index}, 64'd3);
        chk("full_cnt", {48'd0, cycle_count}, 64'd8);
        advance = 1'b1; tick(); tick(); advance = 1'b0;
        chk("full_index_hold", {62'd0, index}, 64'd3);
        chk("full_done_hold", {63'd0, done}, 64'd1);

        // Asynchronous reset mid-program at index 1.
        pulse_clear();
        push(32'hA000_0000, 2'd0);
        push(32'hA000_0001, 2'd1);
        pulse_start();
        run_words(1, "ar");
        wait_valid("ar");
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", {63'd0, instr_valid}, 64'd0);
        chk("ar_index", {62'd0, index}, 64'd0);
        chk("ar_instr", {32'd0, instr}, 64'd0);
        chk("ar_cnt", {48'd0, cycle_count}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        push(32'hA000_0000, 2'd0);
        pulse_start();
        run_words(1, "ar_restart");
        push(32'hA000_0001, 2'd1);
        wait_valid("clr");

        // clear together with advance: back to IDLE, index untouched.
        clear = 1'b1; advance = 1'b1; tick(); clear = 1'b0; advance = 1'b0;
        chk("clr_valid", {63'd0, instr_valid}, 64'd0);
        chk("clr_index", {62'd0, index}, 64'd1);
        chk("clr_done", {63'd0, done}, 64'd0);

        // load_en during ISSUE must not write memory.
        push(32'hA000_0000, 2'd0);
        pulse_start();
        wait_valid("ld");
        load(2'd0, 32'h1234_5678);
        pulse_clear();
        push(32'hA000_0000, 2'd0);
        pulse_start();
        wait_valid("ld_readback");
        tick();

        // Advance on the 16th stalled cycle wins over the watchdog.
        pulse_clear();
        push(32'hA000_0000, 2'd0);
        push(32'hA000_0001, 2'd1);
        pulse_start();
        wait_valid("wdr");
        for (int i = 0; i < 15; i++) tick();
        advance = 1'b1; tick(); advance = 1'b0;
        chk("wdr_tmo", {63'd0, timeout_err}, 64'd0);
        chk("wdr_fetch", {63'd0, instr_valid}, 64'd0);
        chk("wdr_index", {62'd0, index}, 64'd1);
        wait_valid("wdr_next");
        tick();
        pulse_clear();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 64, program memory words (power of two, >=2).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), index width.
REQ-004 SHALL have parameter END_WORD, default all-ones of DATA_W, end-of-program marker.
REQ-005 SHALL have parameter TIMEOUT, default 16, max ISSUE cycles without advance (>=2).
REQ-006 SHALL have parameter CNT_W, default 16, cycle counter width.
REQ-007 SHALL have port clk  input  1  single clock, rising-edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-009 SHALL have port load_en  input  1  program memory write strobe.
REQ-010 SHALL have port load_addr  input  ADDR_W  write address.
REQ-011 SHALL have port load_data  input  DATA_W  write data.
REQ-012 SHALL have port start  input  1  begin/restart program from index 0.
REQ-013 SHALL have port clear  input  1  synchronous return to IDLE.
REQ-014 SHALL have port advance  input  1  consumer accepted current word (PCWrite-style strobe).
REQ-015 SHALL have port instr  output  DATA_W  current instruction word.
REQ-016 SHALL have port instr_valid  output  1  instr is valid for consumption.
REQ-017 SHALL have port index  output  ADDR_W  address of current word.
REQ-018 SHALL have port done  output  1  program finished normally.
REQ-019 SHALL have port timeout_err  output  1  watchdog expired.
REQ-020 SHALL have port cycle_count  output  CNT_W  cycles spent in FETCH/ISSUE.

Function
REQ-021 SHALL implement states IDLE, FETCH, ISSUE, DONE, ERROR, registered.
REQ-022 Memory writes SHALL occur only in IDLE when load_en=1: mem[load_addr] <= load_data; load_en ignored elsewhere.
REQ-023 clear=1 SHALL force IDLE next cycle from any state; clear has priority over start and advance.
REQ-024 IDLE/DONE/ERROR + start=1 (clear=0) SHALL go to FETCH with index<=0, cycle_count<=0, done<=0, timeout_err<=0.
REQ-025 FETCH SHALL last exactly one cycle, registering mem[index] into instr.
REQ-026 FETCH: if read word == END_WORD, next state SHALL be DONE; else ISSUE.
REQ-027 ISSUE SHALL assert instr_valid=1 combinationally from state; instr_valid=0 in all other states.
REQ-028 ISSUE + advance=1: if index == DEPTH-1 next state DONE (no wrap), else index<=index+1 and next state FETCH.
REQ-029 advance outside ISSUE SHALL be ignored.
REQ-030 Watchdog SHALL count ISSUE cycles without advance, clear on entry to ISSUE; on the TIMEOUT-th consecutive such cycle next state SHALL be ERROR.
REQ-031 advance in the same cycle the watchdog expires SHALL win (advance processed, no ERROR).
REQ-032 done SHALL be 1 exactly while in DONE; timeout_err 1 exactly while in ERROR.
REQ-033 cycle_count SHALL increment by 1 each cycle in FETCH or ISSUE, saturate at 2^CNT_W-1, hold otherwise.
REQ-034 Per-word latency: advance at cycle n -> instr_valid=0 at n+1 (FETCH) -> instr_valid=1 with next word at n+2.
REQ-035 index and instr SHALL hold their values in DONE/ERROR for inspection.

Reset
REQ-036 reset=0 SHALL immediately force IDLE, instr=0, index=0, cycle_count=0, watchdog=0, instr_valid=0, done=0, timeout_err=0, asynchronously, including mid-program.
REQ-037 Memory contents SHALL NOT be cleared by reset.
REQ-038 Release of reset SHALL be synchronised to clk by the integrating block; module acts on first rising edge after release.

Verification
REQ-039 Load mem[0..2]=E3A00005,E2801001,FFFFFFFF; start; advance one cycle after each instr_valid -> instr sequence E3A00005,E2801001, then done=1, index=2, cycle_count=5.
REQ-040 Load mem[0]=E3A00005; start; never advance -> instr_valid=1 for 16 cycles, then timeout_err=1, instr_valid=0, index=0.
REQ-041 DEPTH=4, no END_WORD in mem; start; advance each ISSUE -> 4 words issued, done=1 after index 3, index stays 3 (no wrap).
REQ-042 Mid-program (index=1, ISSUE) pulse reset=0 -> outputs reset same cycle; after release mem intact; start reissues mem[0].
REQ-043 In ISSUE assert clear and advance together -> IDLE next cycle, index unchanged; load_en during ISSUE -> mem unchanged (readback via restart).
REQ-044 Advance on 16th stalled ISSUE cycle -> no ERROR, FETCH follows, index incremented.
